// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input.
//
// The input is brought into the clk domain through a 2-flop synchronizer.
// A small IDLE/HIGH/LOW machine counts clk cycles between rising edges and
// publishes the high time and period of each completed period with a
// one-cycle valid pulse. If no rising edge arrives within 2^WIDTH-1 cycles,
// timeout is raised and the synchronized level at that moment is latched in
// stuck_level.
//
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to insert a
// registered 3-sample majority filter after the synchronizer. It rejects
// single-cycle pulses and adds exactly 2 cycles of edge latency.
//
// Ports:
//   clk          - single clock, all logic on its rising edge
//   reset        - synchronous active-high reset
//   pwm_in       - PWM input, asynchronous to clk
//   high_count   - high time (clk cycles) of the last completed period
//   period_count - rising-to-rising distance (clk cycles) of that period
//   valid        - one-cycle pulse when high_count/period_count update
//   timeout      - no rising edge within 2^WIDTH-1 cycles; cleared by valid
//   stuck_level  - synchronized input level when timeout was raised

module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] period_count,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic             sync_meta_r;
  logic             sync_r;
  logic             s_s;
  logic             s_prev_r;
  logic [2:0]       fill_cnt_r;
  logic             armed_r;
  logic             rise_s;
  logic             fall_s;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] high_cnt_r;
  logic [WIDTH-1:0] period_cnt_r;
  logic [WIDTH-1:0] idle_cnt_r;

  logic [1:0]       state_next_s;
  logic [WIDTH-1:0] high_cnt_next_s;
  logic [WIDTH-1:0] period_cnt_next_s;
  logic [WIDTH-1:0] idle_cnt_next_s;
  logic             capture_s;
  logic             timeout_fire_s;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= pwm_in;
      sync_r      <= sync_meta_r;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Cycles after reset until the filtered level reflects real input samples.
  localparam logic [2:0] FILL_CYCLES = 3'd5;

  logic filt_d1_r;
  logic filt_d2_r;
  logic filt_r;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Majority of the last three synchronized samples, registered; a clean
  // edge passes with 2 extra cycles of delay, a 1-cycle pulse never wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d1_r <= 1'b0;
      filt_d2_r <= 1'b0;
      filt_r    <= 1'b0;
    end else begin
      filt_d1_r <= sync_r;
      filt_d2_r <= filt_d1_r;
      filt_r    <= majority3(sync_r, filt_d1_r, filt_d2_r);
    end
  end

  assign s_s = filt_r;
`else
  // Cycles after reset until the synchronized level reflects real samples.
  localparam logic [2:0] FILL_CYCLES = 3'd3;

  assign s_s = sync_r;
`endif

  // Previous-level register for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev_r <= 1'b0;
    end else begin
      s_prev_r <= s_s;
    end
  end

  // Arm rising-edge detection only once a real low level has been seen after
  // reset. The pipeline refills from zero, so a level that was already high
  // when reset released would otherwise look like a rising edge and open a
  // bogus partial period.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt_r <= 3'd0;
      armed_r    <= 1'b0;
    end else begin
      if (fill_cnt_r != FILL_CYCLES) begin
        fill_cnt_r <= fill_cnt_r + 3'd1;
      end
      if ((fill_cnt_r == FILL_CYCLES) && !s_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Edge detection on the (optionally filtered) synchronized level.
  always_comb begin
    rise_s = s_s & ~s_prev_r & armed_r;
    fall_s = ~s_s & s_prev_r;
  end

  // Next-state and counter logic. Priority: rise, then timeout, then fall.
  // Counters restart at 1 on a rise because the rise cycle itself is the
  // first high cycle of the new period.
  always_comb begin
    state_next_s      = state_r;
    high_cnt_next_s   = high_cnt_r;
    period_cnt_next_s = period_cnt_r;
    idle_cnt_next_s   = idle_cnt_r;
    capture_s         = 1'b0;
    timeout_fire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        high_cnt_next_s   = CNT_ZERO;
        period_cnt_next_s = CNT_ZERO;
        if (rise_s) begin
          state_next_s      = ST_HIGH;
          high_cnt_next_s   = CNT_ONE;
          period_cnt_next_s = CNT_ONE;
          idle_cnt_next_s   = CNT_ZERO;
        end else if (idle_cnt_r == (CNT_MAX - CNT_ONE)) begin
          // This is the (2^WIDTH-1)-th idle cycle without a rise.
          timeout_fire_s  = 1'b1;
          idle_cnt_next_s = CNT_ZERO;
        end else begin
          idle_cnt_next_s = idle_cnt_r + CNT_ONE;
        end
      end
      ST_HIGH, ST_LOW: begin
        idle_cnt_next_s = CNT_ZERO;
        if (rise_s) begin
          capture_s         = 1'b1;
          state_next_s      = ST_HIGH;
          high_cnt_next_s   = CNT_ONE;
          period_cnt_next_s = CNT_ONE;
        end else if (period_cnt_r == CNT_MAX) begin
          timeout_fire_s    = 1'b1;
          state_next_s      = ST_IDLE;
          high_cnt_next_s   = CNT_ZERO;
          period_cnt_next_s = CNT_ZERO;
        end else if ((state_r == ST_HIGH) && fall_s) begin
          // The fall cycle is already low: period grows, high time holds.
          state_next_s      = ST_LOW;
          period_cnt_next_s = period_cnt_r + CNT_ONE;
        end else if (state_r == ST_HIGH) begin
          high_cnt_next_s   = high_cnt_r + CNT_ONE;
          period_cnt_next_s = period_cnt_r + CNT_ONE;
        end else begin
          period_cnt_next_s = period_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s      = ST_IDLE;
        high_cnt_next_s   = CNT_ZERO;
        period_cnt_next_s = CNT_ZERO;
        idle_cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      high_cnt_r   <= CNT_ZERO;
      period_cnt_r <= CNT_ZERO;
      idle_cnt_r   <= CNT_ZERO;
    end else begin
      state_r      <= state_next_s;
      high_cnt_r   <= high_cnt_next_s;
      period_cnt_r <= period_cnt_next_s;
      idle_cnt_r   <= idle_cnt_next_s;
    end
  end

  // Registered outputs: results and valid on a completed period, timeout
  // sticky until the next valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_count   <= CNT_ZERO;
      period_count <= CNT_ZERO;
      valid        <= 1'b0;
      timeout      <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      valid <= capture_s;
      if (capture_s) begin
        high_count   <= high_cnt_r;
        period_count <= period_cnt_r;
        timeout      <= 1'b0;
      end else if (timeout_fire_s) begin
        timeout     <= 1'b1;
        stuck_level <= s_s;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: two instances (WIDTH=16 and WIDTH=10) share the
// stimulus. Expected results come from a waveform-level model: the driven
// cycle sequence (median-filtered when the glitch filter is built in) is
// scanned for rising/falling positions, and each pair of consecutive rises
// yields one expected (high, period) result.

module tb_pwm_capture;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
  localparam int LAT       = 5;
`else
  localparam bit FILTER_EN = 1'b0;
  localparam int LAT       = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [15:0] hc16, pc16;
  logic        v16, to16, st16;
  logic [9:0]  hc10, pc10;
  logic        v10, to10, st10;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_high_q[$];
  int exp_period_q[$];
  int eh, ep;

  logic seg_lvl[$];
  int   seg_len[$];

  pwm_capture #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .high_count(hc16), .period_count(pc16),
    .valid(v16), .timeout(to16), .stuck_level(st16)
  );

  pwm_capture #(.WIDTH(10)) dut10 (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .high_count(hc10), .period_count(pc10),
    .valid(v10), .timeout(to10), .stuck_level(st10)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    tick(n);
  endtask

  task automatic expect_result(input int h, input int p);
    exp_high_q.push_back(h);
    exp_period_q.push_back(p);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(8);
  endtask

  task automatic check_drained(input string tag);
    tick(8);
    check_value({tag, "_pending"}, exp_high_q.size(), 0);
  endtask

  task automatic add_seg(input logic lvl, input int n);
    seg_lvl.push_back(lvl);
    seg_len.push_back(n);
  endtask

  // Build the per-cycle waveform, derive expected results, then drive it.
  task automatic run_segments();
    logic wave[$];
    logic filt[$];
    logic a, b, c, prev;
    int   prev_r, last_f;
    wave = {};
    filt = {};
    foreach (seg_lvl[i]) begin
      for (int k = 0; k < seg_len[i]; k++) wave.push_back(seg_lvl[i]);
    end
    foreach (wave[i]) begin
      if (FILTER_EN) begin
        a = (i > 0) ? wave[i-1] : 1'b0;
        b = wave[i];
        c = (i < wave.size() - 1) ? wave[i+1] : wave[i];
        filt.push_back((a & b) | (a & c) | (b & c));
      end else begin
        filt.push_back(wave[i]);
      end
    end
    prev   = 1'b0;
    prev_r = -1;
    last_f = -1;
    foreach (filt[i]) begin
      if (filt[i] && !prev) begin
        if (prev_r >= 0) expect_result(last_f - prev_r, i - prev_r);
        prev_r = i;
      end
      if (!filt[i] && prev) last_f = i;
      prev = filt[i];
    end
    foreach (seg_lvl[i]) drive(seg_lvl[i], seg_len[i]);
    seg_lvl.delete();
    seg_len.delete();
  endtask

  // Scoreboard: every valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (v16 === 1'b1 || v10 === 1'b1) begin
      check_value("valid_expected", exp_high_q.size() > 0, 1);
      if (exp_high_q.size() > 0) begin
        eh = exp_high_q.pop_front();
        ep = exp_period_q.pop_front();
        check_value("valid16", v16, 1);
        check_value("valid10", v10, 1);
        check_value("high16", hc16, eh);
        check_value("period16", pc16, ep);
        check_value("high10", hc10, eh);
        check_value("period10", pc10, ep);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    check_value("rst_high", hc16, 0);
    check_value("rst_period", pc16, 0);
    check_value("rst_valid", v16, 0);
    check_value("rst_timeout", to16, 0);
    check_value("rst_stuck", st16, 0);
    reset = 1'b0;
    tick(8);

    // Steady 64/192 signal.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_seg(1'b1, 64);
      add_seg(1'b0, 192);
    end
    add_seg(1'b1, 10);
    add_seg(1'b0, 5);
    run_segments();
    check_drained("steady");

    // Random high/low times.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      add_seg(1'b1, $urandom_range(3, 40));
      add_seg(1'b0, $urandom_range(3, 40));
    end
    add_seg(1'b1, 8);
    add_seg(1'b0, 4);
    run_segments();
    check_drained("random");

    // 50/50 signal with a 1-cycle low glitch in one high phase.
    do_reset();
    add_seg(1'b1, 50); add_seg(1'b0, 50);
    add_seg(1'b1, 20); add_seg(1'b0, 1); add_seg(1'b1, 29); add_seg(1'b0, 50);
    add_seg(1'b1, 50); add_seg(1'b0, 50);
    add_seg(1'b1, 10); add_seg(1'b0, 5);
    run_segments();
    check_drained("glitch");

    // Edge latency from the first high sample to valid.
    do_reset();
    drive(1'b1, 20);
    drive(1'b0, 20);
    expect_result(20, 40);
    pwm_in = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick(1);
      check_value($sformatf("latency_c%0d", j), v16, (j == LAT) ? 1 : 0);
    end
    drive(1'b1, 4);
    drive(1'b0, 5);
    check_drained("latency");

    // Input stuck low: timeout after 2^10-1 cycles, then cleared by valid.
    do_reset();
    tick(990);
    check_value("to_low_early", to10, 0);
    tick(40);
    check_value("to_low_set", to10, 1);
    check_value("to_low_stuck", st10, 0);
    check_value("to_low_high", hc10, 0);
    check_value("to_low_period", pc10, 0);
    check_value("to_low_wide16", to16, 0);
    drive(1'b1, 10);
    check_value("to_low_first_rise", to10, 1);
    drive(1'b0, 20);
    expect_result(10, 30);
    drive(1'b1, 10);
    check_value("to_low_cleared", to10, 0);
    drive(1'b0, 20);
    check_drained("to_low");

    // Input stuck high: timeout, stuck_level=1, results held.
    do_reset();
    drive(1'b1, 10);
    drive(1'b0, 20);
    expect_result(10, 30);
    drive(1'b1, 1100);
    check_value("to_high_set", to10, 1);
    check_value("to_high_stuck", st10, 1);
    check_value("to_high_high", hc10, 10);
    check_value("to_high_period", pc10, 30);
    check_value("to_high_wide16", to16, 0);
    drive(1'b0, 10);
    check_drained("to_high");

    // Reset in the middle of a high phase of a 100/200 signal.
    do_reset();
    drive(1'b1, 100);
    drive(1'b0, 200);
    expect_result(100, 300);
    drive(1'b1, 50);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check_value("midrst_high", hc16, 0);
    check_value("midrst_period", pc16, 0);
    drive(1'b1, 49);
    drive(1'b0, 200);
    drive(1'b1, 100);
    drive(1'b0, 200);
    expect_result(100, 300);
    drive(1'b1, 10);
    drive(1'b0, 10);
    check_drained("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the width of the count outputs and internal counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pwm_in, input, 1, PWM signal asynchronous to clk.
REQ-005 SHALL have port high_count, output, WIDTH, high-time in clk cycles of the last completed period.
REQ-006 SHALL have port period_count, output, WIDTH, rising-to-rising distance in clk cycles of the last completed period.
REQ-007 SHALL have port valid, output, 1, single-cycle pulse when high_count and period_count update.
REQ-008 SHALL have port timeout, output, 1, set when no rising edge arrives within 2^WIDTH-1 cycles.
REQ-009 SHALL have port stuck_level, output, 1, synchronized pwm_in level captured at the cycle timeout sets.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchronizer; all edge detection SHALL use the synchronized signal s (post-filter when REQ-026 applies).
REQ-011 SHALL detect rise = s & ~s_prev and fall = ~s & s_prev from registered s_prev.
REQ-012 SHALL implement states IDLE, HIGH, LOW.
REQ-013 IDLE: counters held at 0; on rise go to HIGH with period counter = 1, high counter = 1.
REQ-014 HIGH: both counters increment each cycle; on fall go to LOW.
REQ-015 LOW: period counter increments, high counter holds; on rise go to HIGH.
REQ-016 On rise in HIGH or LOW: register period_count and high_count from the counters, pulse valid for one cycle, clear timeout, restart counters at 1.
REQ-017 A clean rising edge first sampled high by clk at cycle k SHALL produce valid in cycle k+3 (no filter).
REQ-018 A period of P cycles with H high cycles SHALL report period_count = P, high_count = H, exactly.
REQ-019 If the period counter reaches 2^WIDTH-1 in HIGH or LOW, or if IDLE lasts 2^WIDTH-1 cycles with no rise: set timeout, latch stuck_level = s, go to IDLE, no valid pulse.
REQ-020 timeout SHALL remain set until the next valid pulse or reset; high_count/period_count SHALL keep their last values.
REQ-021 Counters SHALL never wrap; the timeout of REQ-019 fires before overflow.
REQ-022 The first rise after IDLE SHALL NOT produce valid; valid needs one complete period.
REQ-023 A rise and a timeout condition in the same cycle SHALL be treated as a rise (REQ-016 wins).

Reset
REQ-024 During reset: state = IDLE, counters, synchronizer, filter and s_prev = 0, high_count = 0, period_count = 0, valid = 0, timeout = 0, stuck_level = 0.
REQ-025 Reset asserted mid-measurement SHALL discard the partial period; the first valid after release needs one full period after the first rise.

Configuration
REQ-026 With PWM_CAPTURE_GLITCH_FILTER_EN defined: a 3-sample majority filter SHALL follow the synchronizer; single-cycle pulses or glitches are rejected; edge latency grows by exactly 2 cycles (valid at k+5); clean-signal counts are unchanged.
REQ-027 Without PWM_CAPTURE_GLITCH_FILTER_EN: no filter; every synchronized transition is an edge, including 1-cycle pulses.

Verification
REQ-028 WIDTH=16, periodic 64 high / 192 low -> from the second rise on, each rise gives valid with high_count=64, period_count=256.
REQ-029 WIDTH=10, pwm_in held 0 after reset -> timeout=1, stuck_level=0 after 1023 cycles; a later 10/20 signal clears timeout at the first valid with high_count=10, period_count=30.
REQ-030 WIDTH=10, pwm_in held 1 -> timeout=1, stuck_level=1; high_count/period_count unchanged.
REQ-031 Reset pulsed mid-HIGH of a 100/200 signal -> no valid for the broken period; next valid reports high_count=100, period_count=300.
REQ-032 Filter enabled, 50/50 signal with a 1-cycle low glitch inside the high phase -> high_count=50, period_count=100; filter disabled -> a period split at the glitch is reported.
REQ-033 Edge latency: a single clean rise after a steady period -> valid exactly 3 cycles (5 with filter) after the first high sample.
